// File: rtl/ab_collect_pkg.sv
// Shared types and helpers for the A/B result collector: op and state enums,
// the y/z combine rule and a fixed-width popcount.
package ab_collect_pkg;

    // popcount operates on this many bits; collector words must not be wider
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XNOR = 2'd3
    } op_e;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    function automatic logic combine(input op_e op, input logic y, input logic z);
        case (op)
            OP_XOR:  return y ^ z;
            OP_AND:  return y & z;
            OP_OR:   return y | z;
            OP_XNOR: return ~(y ^ z);
            default: return y ^ z;
        endcase
    endfunction

    function automatic logic [6:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ab_shift_assembler.sv
// LSB-first bit accumulator. word/len show the accumulator with this cycle's
// accepted bit already merged, so a closing word can be captured directly.
module ab_shift_assembler
    import ab_collect_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic             bit_in,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] len
);

    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign word[gi] = (accept && (cnt_reg == CNT_W'(gi))) ? bit_in : acc_reg[gi];
        end
    endgenerate

    assign len = cnt_reg + CNT_W'(accept);

    // clear wins: the merged word has already been taken by the output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            acc_reg <= word;
            cnt_reg <= len;
        end
    end

endmodule

// File: rtl/ab_result_collector.sv
// Combines A/B result bit pairs, packs them into WIDTH-bit words and emits them
// on a 1-deep valid/ready output. Optional out_parity port: AB_COLLECT_PARITY_EN.
module ab_result_collector
    import ab_collect_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int OP    = 0,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y,
    input  logic             z,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic [CNT_W-1:0] out_ones,
`ifdef AB_COLLECT_PARITY_EN
    output logic             out_parity,
`endif
    output logic [15:0]      word_count
);

    localparam op_e OP_SEL = op_e'(OP[1:0]);

    state_e           state_reg, state_next;
    logic             accept, in_bit, close, drain, slot_free, load;
    logic [WIDTH-1:0] asm_word;
    logic [CNT_W-1:0] asm_len;
    logic [CNT_W-1:0] ones_next;

    assign in_bit    = combine(OP_SEL, y, z);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    // asm_len can only reach WIDTH through this cycle's accept
    assign close = (state_reg == FILL) &&
                   ((asm_len == CNT_W'(WIDTH)) || (flush && (asm_len != '0)));

    assign ones_next = CNT_W'(popcount(MAX_WIDTH'(asm_word)));

    ab_shift_assembler #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .bit_in (in_bit),
        .clear  (load),
        .word   (asm_word),
        .len    (asm_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (close && !slot_free) state_next = FULL;
            FULL:    if (drain)               state_next = FILL;
            default:                          state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == FILL);
        load     = (close && slot_free) || ((state_reg == FULL) && drain);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            out_ones  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= asm_word;
            out_len   <= asm_len;
            out_ones  <= ones_next;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef AB_COLLECT_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= ^asm_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count <= '0;
        end else if (drain) begin
            word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ab_result_collector.sv
// Directed + random bench for ab_result_collector against a queue-based word model.
module tb_ab_result_collector;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, y, z, flush, out_ready;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_len, out_ones;
    logic [15:0]      word_count;
    logic             a_in_ready, a_out_valid;
    logic [WIDTH-1:0] a_out_data;
    logic [CNT_W-1:0] a_out_len, a_out_ones;
    logic [15:0]      a_word_count;
`ifdef AB_COLLECT_PARITY_EN
    logic             out_parity, a_out_parity;
`endif

    always #5 clk = ~clk;

    ab_result_collector #(.WIDTH(WIDTH), .OP(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .z(z), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_len(out_len), .out_ones(out_ones),
`ifdef AB_COLLECT_PARITY_EN
        .out_parity(out_parity),
`endif
        .word_count(word_count)
    );

    ab_result_collector #(.WIDTH(WIDTH), .OP(1)) dut_and (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .y(y), .z(z), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_len(a_out_len), .out_ones(a_out_ones),
`ifdef AB_COLLECT_PARITY_EN
        .out_parity(a_out_parity),
`endif
        .word_count(a_word_count)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               len;
        int               ones;
    } word_t;

    int     tests = 0;
    int     fails = 0;
    logic   part[$];
    word_t  exp_q[$];
    int     wc_model = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_op(input int op, input logic a, input logic b);
        case (op)
            0:       return a ^ b;
            1:       return a & b;
            2:       return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic close_word();
        word_t w;
        w.data = '0;
        w.ones = 0;
        w.len  = part.size();
        for (int i = 0; i < part.size(); i++) begin
            w.data[i] = part[i];
            if (part[i]) w.ones++;
        end
        exp_q.push_back(w);
        part.delete();
    endtask

    // One clock: drive, check pre-edge view against the model, advance model and clock.
    task automatic step(input logic v, input logic yy, input logic zz,
                        input logic fl, input logic ordy);
        bit acc, hs;
        in_valid = v; y = yy; z = zz; flush = fl; out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("word_count", 32'(word_count), 32'(wc_model));
        if (exp_q.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_len", 32'(out_len), 32'(exp_q[0].len));
            chk("out_ones", 32'(out_ones), 32'(exp_q[0].ones));
`ifdef AB_COLLECT_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(^exp_q[0].data));
`endif
        end
        acc = v && (exp_q.size() < 2);
        hs  = ordy && (exp_q.size() > 0);
        if (hs) begin
            void'(exp_q.pop_front());
            wc_model = (wc_model + 1) & 16'hFFFF;
        end
        if (acc) part.push_back(model_op(0, yy, zz));
        if (part.size() == WIDTH) close_word();
        else if (fl && part.size() > 0) close_word();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; y = 0; z = 0; flush = 0; out_ready = 0;
        rst = 0;
        #1;
        part.delete();
        exp_q.delete();
        wc_model = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_len", 32'(out_len), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
`ifdef AB_COLLECT_PARITY_EN
        chk("rst_out_parity", 32'(out_parity), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        logic [7:0]       pat;
        logic [WIDTH-1:0] and_exp;
        int               and_ones;
        int               wc0;
        pat = 8'h8D;

        do_reset();

        // bits 1,0,1,1,0,0,0,1 -> 0x8D
        for (int i = 0; i < 8; i++) step(1, pat[i], 0, 0, 1);
        chk("t2_data", 32'(out_data), 32'h8D);
        chk("t2_len", 32'(out_len), 32'd8);
        chk("t2_ones", 32'(out_ones), 32'd4);
        step(0, 0, 0, 0, 1);

        // stall: 16 pairs fill output slot and accumulator
        for (int i = 0; i < 16; i++) step(1, 1'($urandom), 1'($urandom), 0, 0);
        chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        step(0, 0, 0, 1, 1);
        chk("t3_in_ready_back", 32'(in_ready), 32'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // partial word by flush
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("t4_data", 32'(out_data), 32'h03);
        chk("t4_len", 32'(out_len), 32'd3);
        chk("t4_ones", 32'(out_ones), 32'd2);
        step(0, 0, 0, 1, 1);   // flush with nothing pending
        step(0, 0, 0, 0, 1);

        // flush together with the 8th accept
        wc0 = int'(word_count);
        for (int i = 0; i < 7; i++) step(1, 1'($urandom), 0, 0, 1);
        step(1, 1, 0, 1, 1);
        chk("t5_len", 32'(out_len), 32'd8);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_word_count", 32'(word_count), 32'(wc0 + 1));

        // partial word discarded by reset
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1'(i % 3 == 0), 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t6_word_count", 32'(word_count), 32'd1);

        // AND sweep on the OP=1 instance (XOR instance still model-checked)
        do_reset();
        and_exp  = '0;
        and_ones = 0;
        for (int i = 0; i < 8; i++) begin
            logic yy, zz;
            yy = 1'(i >> 1);
            zz = 1'(i);
            and_exp[i] = model_op(1, yy, zz);
            if (and_exp[i]) and_ones++;
            step(1, yy, zz, 0, 1);
        end
        chk("and_valid", 32'(a_out_valid), 32'd1);
        chk("and_data", 32'(a_out_data), 32'(and_exp));
        chk("and_len", 32'(a_out_len), 32'd8);
        chk("and_ones", 32'(a_out_ones), 32'(and_ones));
        chk("and_in_ready", 32'(a_in_ready), 32'd1);
`ifdef AB_COLLECT_PARITY_EN
        chk("and_parity", 32'(a_out_parity), 32'(^and_exp));
`endif
        step(0, 0, 0, 0, 1);
        chk("and_word_count", 32'(a_word_count), 32'd1);

        // random traffic with stalls and flushes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 9) == 0), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
